// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path and ALU control decoder.
package mips_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned STATE_W  = 4;

  // Supported opcodes (IR[31:26])
  localparam logic [OPCODE_W-1:0] OP_R    = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J    = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;

  // Control FSM state encodings
  localparam logic [STATE_W-1:0] S_FETCH  = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE = 4'd1;
  localparam logic [STATE_W-1:0] S_MEMADR = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMRD  = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMWB  = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWR  = 4'd5;
  localparam logic [STATE_W-1:0] S_EXEC   = 4'd6;
  localparam logic [STATE_W-1:0] S_ALUWB  = 4'd7;
  localparam logic [STATE_W-1:0] S_BRANCH = 4'd8;
  localparam logic [STATE_W-1:0] S_JUMP   = 4'd9;
  localparam logic [STATE_W-1:0] S_ADDIEX = 4'd10;
  localparam logic [STATE_W-1:0] S_ADDIWB = 4'd11;

  // ALU operation class handed to the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control word
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
  } ctrl_t;

  // True for opcodes this control unit can sequence
  function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational decode of FSM state (plus mem_ready/opcode) into the control word.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  logic [STATE_W-1:0]  state,
  input  logic                mem_ready,
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl_c,
  output logic                illegal_c
);

  // Per-state control word; anything not set stays 0, unused codes decode to all-zero
  always_comb begin
    ctrl_c    = '0;
    illegal_c = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl_c.alu_src_b = SRCB_IMM_SH;
        illegal_c        = !op_legal(opcode);
      end
      S_MEMADR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_B;
        ctrl_c.aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = SRCB_B;
        ctrl_c.aluop         = ALUOP_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.aluop     = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl_c.reg_write = 1'b1;
      end
      default: begin
        ctrl_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned OP_W = 6,
  parameter int unsigned ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      aluop,
  output logic [1:0]      pc_source,
  output logic            illegal_op,
  output logic [ST_W-1:0] state
);

  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;
  ctrl_t           ctrl_c;
  ctrl_t           ctrl_g;
  logic            illegal_c;

  // State register; reset restarts at FETCH and drops any in-flight access
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic; memory states hold until mem_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .opcode    (opcode),
    .ctrl_c    (ctrl_c),
    .illegal_c (illegal_c)
  );

  // Reset silences every output immediately, not only after the clock edge
  assign ctrl_g        = rst ? '0 : ctrl_c;
  assign illegal_op    = rst ? 1'b0 : illegal_c;
  assign state         = rst ? '0 : state_q;

  assign pc_write      = ctrl_g.pc_write;
  assign pc_write_cond = ctrl_g.pc_write_cond;
  assign iord          = ctrl_g.iord;
  assign mem_read      = ctrl_g.mem_read;
  assign mem_write     = ctrl_g.mem_write;
  assign ir_write      = ctrl_g.ir_write;
  assign mem_to_reg    = ctrl_g.mem_to_reg;
  assign reg_dst       = ctrl_g.reg_dst;
  assign reg_write     = ctrl_g.reg_write;
  assign alu_src_a     = ctrl_g.alu_src_a;
  assign alu_src_b     = ctrl_g.alu_src_b;
  assign aluop         = ctrl_g.aluop;
  assign pc_source     = ctrl_g.pc_source;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for the multicycle MIPS control FSM.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, aluop, pc_source;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    logic       ill;
  } vec_t;

  vec_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  mips_multicycle_control #(.OP_W(6), .ST_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Reference control word for a state, straight from the state table
  function automatic vec_t model(input logic r, input logic [3:0] st,
                                 input logic mr, input logic [5:0] op);
    vec_t v = '0;
    logic legal;
    legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
    if (r) return v;
    v.st = st;
    case (st)
      4'd0:  begin v.mrd = 1; v.asb = 2'b01; v.irw = mr; v.pcw = mr; end
      4'd1:  begin v.asb = 2'b11; v.ill = !legal; end
      4'd2:  begin v.asa = 1; v.asb = 2'b10; end
      4'd3:  begin v.mrd = 1; v.iord = 1; end
      4'd4:  begin v.rw = 1; v.m2r = 1; end
      4'd5:  begin v.mwr = 1; v.iord = 1; end
      4'd6:  begin v.asa = 1; v.aop = 2'b10; end
      4'd7:  begin v.rw = 1; v.rdst = 1; end
      4'd8:  begin v.asa = 1; v.aop = 2'b01; v.pcwc = 1; v.psrc = 2'b01; end
      4'd9:  begin v.pcw = 1; v.psrc = 2'b10; end
      4'd10: begin v.asa = 1; v.asb = 2'b10; end
      4'd11: begin v.rw = 1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  // One cycle: drive on negedge, push expectation, sample 1ns later, pop and compare
  task automatic step(input string tag, input logic r, input logic [5:0] op,
                      input logic mr, input logic [3:0] exp_st);
    vec_t act, expv;
    @(negedge clk);
    rst = r; opcode = op; mem_ready = mr;
    exp_q.push_back(model(r, exp_st, mr, op));
    #1;
    act = '{state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, aluop,
            pc_source, illegal_op};
    expv = exp_q.pop_front();
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s vec%0d: got state=%0d word=%h, expected state=%0d word=%h",
               tag, vectors, act.st, act, expv.st, expv);
    end
    if (mem_read === 1'b1 && mem_write === 1'b1) begin
      miscompares++;
      $display("FAIL %s vec%0d: mem_read and mem_write both 1, expected exclusive",
               tag, vectors);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 6'b000010, 1'b1, 4'd0);
    step("reset_first_fetch", 1'b0, 6'b000010, 1'b1, 4'd0);
    step("j_decode", 1'b0, 6'b000010, 1'b1, 4'd1);
    step("j_jump",   1'b0, 6'b000010, 1'b1, 4'd9);
  endtask

  task automatic test_lw();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    foreach (seq[i]) step("lw_seq", 1'b0, 6'b100011, 1'b1, seq[i]);
  endtask

  task automatic test_fetch_stall();
    for (int i = 0; i < 3; i++) step("fetch_stall", 1'b0, 6'b001000, 1'b0, 4'd0);
    step("fetch_release", 1'b0, 6'b001000, 1'b1, 4'd0);
    step("addi_decode",   1'b0, 6'b001000, 1'b1, 4'd1);
    step("addi_ex",       1'b0, 6'b001000, 1'b1, 4'd10);
    step("addi_wb",       1'b0, 6'b001000, 1'b1, 4'd11);
  endtask

  task automatic test_r_beq();
    logic [3:0] rseq [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    logic [3:0] bseq [3] = '{4'd0, 4'd1, 4'd8};
    foreach (rseq[i]) step("r_seq",   1'b0, 6'b000000, 1'b1, rseq[i]);
    foreach (bseq[i]) step("beq_seq", 1'b0, 6'b000100, 1'b1, bseq[i]);
  endtask

  task automatic test_illegal_sw();
    step("ill_fetch",  1'b0, 6'b111111, 1'b1, 4'd0);
    step("ill_decode", 1'b0, 6'b111111, 1'b1, 4'd1);
    step("sw_fetch",   1'b0, 6'b101011, 1'b1, 4'd0);
    step("sw_decode",  1'b0, 6'b101011, 1'b1, 4'd1);
    step("sw_memadr",  1'b0, 6'b101011, 1'b1, 4'd2);
    step("sw_stall",   1'b0, 6'b101011, 1'b0, 4'd5);
    step("sw_stall",   1'b0, 6'b101011, 1'b0, 4'd5);
    step("sw_done",    1'b0, 6'b101011, 1'b1, 4'd5);
  endtask

  task automatic test_reset_mid_lw();
    step("mid_fetch",  1'b0, 6'b100011, 1'b1, 4'd0);
    step("mid_decode", 1'b0, 6'b100011, 1'b1, 4'd1);
    step("mid_memadr", 1'b0, 6'b100011, 1'b1, 4'd2);
    step("mid_memrd",  1'b0, 6'b100011, 1'b0, 4'd3);
    step("mid_rst",    1'b1, 6'b100011, 1'b1, 4'd0);
    step("mid_rst",    1'b1, 6'b100011, 1'b1, 4'd0);
    step("mid_restart", 1'b0, 6'b100011, 1'b0, 4'd0);
    step("mid_restart", 1'b0, 6'b100011, 1'b0, 4'd0);
  endtask

  initial begin
    rst = 1'b1; opcode = 6'b000000; mem_ready = 1'b1;
    test_reset();
    test_lw();
    test_fetch_stall();
    test_r_beq();
    test_illegal_sw();
    test_reset_mid_lw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
